// File: rtl/ofdm_cp_insert_if.sv
// Sample stream bundle between the IFFT, the cyclic-prefix inserter and the DAC/packet stage.
// slave: the inserter side; master: the producer/consumer (bench or neighbouring blocks).
interface ofdm_cp_insert_if #(
   parameter int DATA_WIDTH = 22,
   parameter int OUT_WIDTH  = 16
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_data_i;
   logic signed [DATA_WIDTH-1:0] in_data_q;
   logic                         out_valid;
   logic                         out_ready;
   logic        [OUT_WIDTH-1:0]  out_data_i;
   logic        [OUT_WIDTH-1:0]  out_data_q;
   logic                         out_sop;
   logic                         out_eop;
   logic                         out_cp;
   logic        [15:0]           sym_count;

   modport slave (
      input  in_valid, in_data_i, in_data_q, out_ready,
      output in_ready, out_valid, out_data_i, out_data_q, out_sop, out_eop, out_cp, sym_count
   );

   modport master (
      output in_valid, in_data_i, in_data_q, out_ready,
      input  in_ready, out_valid, out_data_i, out_data_q, out_sop, out_eop, out_cp, sym_count
   );
endinterface

// File: rtl/ofdm_cp_insert.sv
// Cyclic-prefix inserter: buffers one IFFT symbol, then replays its last CP_LEN samples
// followed by the whole symbol, narrowing each sample to OUT_WIDTH bits.
// Optional macro OFDM_CP_ROUND_EN: round-half-up with positive saturation instead of truncation.
module ofdm_cp_insert #(
   parameter int FFT_SIZE   = 256,
   parameter int CP_LEN     = 64,
   parameter int DATA_WIDTH = 22,
   parameter int OUT_WIDTH  = 16
) (
   input logic             clk,
   input logic             reset,
   ofdm_cp_insert_if.slave bus
);
   localparam int             AW       = $clog2(FFT_SIZE);
   localparam int             SH       = DATA_WIDTH - OUT_WIDTH;
   localparam logic [AW-1:0]  CP_START = AW'(FFT_SIZE - CP_LEN);
   localparam logic [AW-1:0]  LAST     = AW'(FFT_SIZE - 1);
`ifdef OFDM_CP_ROUND_EN
   localparam logic [DATA_WIDTH:0] HALF = (SH > 0) ? ((DATA_WIDTH+1)'(1) << ((SH > 0) ? SH - 1 : 0)) : '0;
`endif

   typedef enum logic [1:0] {IDLE, LOAD, EMIT_CP, EMIT_SYM} state_t;

   state_t                       r_state, w_state_nxt;
   logic        [AW-1:0]         r_wr_addr, r_rd_addr;
   logic signed [DATA_WIDTH-1:0] r_mem_i [FFT_SIZE];
   logic signed [DATA_WIDTH-1:0] r_mem_q [FFT_SIZE];
   logic                         r_last_issued;
   logic                         r_out_valid, r_sop, r_eop, r_cp;
   logic        [OUT_WIDTH-1:0]  r_out_i, r_out_q;
   logic        [15:0]           r_sym_count;
   logic                         w_in_ready, w_in_acc, w_load_done;
   logic                         w_out_free, w_out_xfer, w_issue, w_eop_done;
   logic signed [DATA_WIDTH-1:0] w_rd_i, w_rd_q;

   // Narrow one sample to the output width (truncate, or round-half-up with saturation).
   function automatic logic [OUT_WIDTH-1:0] f_reduce(input logic signed [DATA_WIDTH-1:0] d);
`ifdef OFDM_CP_ROUND_EN
      logic [DATA_WIDTH:0] v_sum;
      if (SH == 0) return d[DATA_WIDTH-1 -: OUT_WIDTH];
      v_sum = {d[DATA_WIDTH-1], d} + HALF;
      // Adding a positive constant can only overflow upwards: clamp to the largest positive code.
      if (!v_sum[DATA_WIDTH] && v_sum[DATA_WIDTH-1]) return {1'b0, {(OUT_WIDTH-1){1'b1}}};
      return v_sum[DATA_WIDTH-1 -: OUT_WIDTH];
`else
      return d[DATA_WIDTH-1 -: OUT_WIDTH];
`endif
   endfunction

   assign w_in_acc    = bus.in_valid && w_in_ready;
   assign w_load_done = w_in_acc && (r_wr_addr == LAST);
   assign w_out_free  = !r_out_valid || bus.out_ready;
   assign w_out_xfer  = r_out_valid && bus.out_ready;
   assign w_issue     = w_out_free && ((r_state == EMIT_CP) || ((r_state == EMIT_SYM) && !r_last_issued));
   assign w_eop_done  = w_out_xfer && r_eop;
   assign w_rd_i      = r_mem_i[r_rd_addr];
   assign w_rd_q      = r_mem_q[r_rd_addr];

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next state; input side is open only while capturing a symbol.
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (w_in_acc) w_state_nxt = LOAD;
         end
         LOAD: begin
            w_in_ready = 1'b1;
            if (w_load_done) w_state_nxt = (CP_LEN == 0) ? EMIT_SYM : EMIT_CP;
         end
         EMIT_CP:  if (w_issue && (r_rd_addr == LAST)) w_state_nxt = EMIT_SYM;
         EMIT_SYM: if (w_eop_done) w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   // Symbol buffer; contents after a reset are don't-care, so no reset here.
   always_ff @(posedge clk) begin
      if (w_in_acc) begin
         r_mem_i[r_wr_addr] <= bus.in_data_i;
         r_mem_q[r_wr_addr] <= bus.in_data_q;
      end
   end

   // Address pointers; the write pointer wraps to 0 on the last sample of a symbol.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_addr     <= '0;
         r_rd_addr     <= '0;
         r_last_issued <= 1'b0;
      end else begin
         if (w_in_acc) r_wr_addr <= r_wr_addr + 1'b1;
         if (w_load_done)  r_rd_addr <= CP_START;
         else if (w_issue) r_rd_addr <= r_rd_addr + 1'b1;
         if (w_issue && (r_state == EMIT_SYM) && (r_rd_addr == LAST)) r_last_issued <= 1'b1;
         else if (w_eop_done)                                         r_last_issued <= 1'b0;
      end
   end

   // Output register stage: load a new sample when the slot is empty or being drained; hold on stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_i     <= '0;
         r_out_q     <= '0;
         r_sop       <= 1'b0;
         r_eop       <= 1'b0;
         r_cp        <= 1'b0;
      end else if (w_issue) begin
         r_out_valid <= 1'b1;
         r_out_i     <= f_reduce(w_rd_i);
         r_out_q     <= f_reduce(w_rd_q);
         r_sop       <= (r_state == EMIT_CP) ? (r_rd_addr == CP_START) : ((CP_LEN == 0) && (r_rd_addr == '0));
         r_eop       <= (r_state == EMIT_SYM) && (r_rd_addr == LAST);
         r_cp        <= (r_state == EMIT_CP);
      end else if (w_out_xfer) begin
         r_out_valid <= 1'b0;
         r_sop       <= 1'b0;
         r_eop       <= 1'b0;
         r_cp        <= 1'b0;
      end
   end

   // Completed-frame counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)           r_sym_count <= '0;
      else if (w_eop_done) r_sym_count <= r_sym_count + 1'b1;
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_data_i = r_out_i;
   assign bus.out_data_q = r_out_q;
   assign bus.out_sop    = r_sop;
   assign bus.out_eop    = r_eop;
   assign bus.out_cp     = r_cp;
   assign bus.sym_count  = r_sym_count;
endmodule

// File: tb/tb_ofdm_cp_insert.sv
// Bench for ofdm_cp_insert: FFT_SIZE=16 with CP_LEN=4 (main DUT) and CP_LEN=0 (second DUT),
// both fed from the same stimulus. Expected frames come from a sample-level model of the framing
// and an integer-arithmetic model of the width reduction.
module tb_ofdm_cp_insert;
   localparam int N = 16, CP = 4, DW = 22, OW = 16, FR = N + CP;

   typedef struct packed {
      logic [OW-1:0] i;
      logic [OW-1:0] q;
      logic          sop;
      logic          eop;
      logic          cpf;
   } smp_t;

   logic                 clk = 1'b0, rst = 1'b0;
   logic                 in_valid = 1'b0, out_ready = 1'b1;
   logic signed [DW-1:0] in_i = '0, in_q = '0;
   int                   n_vec = 0, n_err = 0, cyc = 0, last_acc = 0, exp_sym = 0;
   logic signed [DW-1:0] sym_i [N];
   logic signed [DW-1:0] sym_q [N];
   logic signed [DW-1:0] off_i [53];
   logic signed [DW-1:0] off_q [53];
   smp_t                 mq4[$], mq0[$], exp_q[$];
   int                   mc4[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ofdm_cp_insert_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) if4 ();
   ofdm_cp_insert_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) if0 ();

   assign if4.in_valid  = in_valid;
   assign if4.in_data_i = in_i;
   assign if4.in_data_q = in_q;
   assign if4.out_ready = out_ready;
   assign if0.in_valid  = in_valid;
   assign if0.in_data_i = in_i;
   assign if0.in_data_q = in_q;
   assign if0.out_ready = out_ready;

   ofdm_cp_insert #(.FFT_SIZE(N), .CP_LEN(CP), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) u_dut4 (
      .clk(clk), .reset(rst), .bus(if4));
   ofdm_cp_insert #(.FFT_SIZE(N), .CP_LEN(0), .DATA_WIDTH(DW), .OUT_WIDTH(OW)) u_dut0 (
      .clk(clk), .reset(rst), .bus(if0));

   // Record every output transfer (sampled mid-cycle, the transfer happens on the next rising edge).
   always @(negedge clk) begin : mon
      smp_t s4, s0;
      s4.i = if4.out_data_i; s4.q = if4.out_data_q; s4.sop = if4.out_sop; s4.eop = if4.out_eop; s4.cpf = if4.out_cp;
      s0.i = if0.out_data_i; s0.q = if0.out_data_q; s0.sop = if0.out_sop; s0.eop = if0.out_eop; s0.cpf = if0.out_cp;
      if (!rst && if4.out_valid && if4.out_ready) begin mq4.push_back(s4); mc4.push_back(cyc); end
      if (!rst && if0.out_valid && if0.out_ready) mq0.push_back(s0);
   end

   // Width-reduction model: floor division by 2^(DW-OW), optionally rounded and clamped.
   function automatic logic [OW-1:0] red(input logic signed [DW-1:0] x);
      longint v;
      v = x;
`ifdef OFDM_CP_ROUND_EN
      v = (v + 32) >>> 6;
      if (v > 32767) v = 32767;
`else
      v = v >>> 6;
`endif
      return v[OW-1:0];
   endfunction

   // Framing model: prefix = last ncp samples, then the whole symbol.
   function automatic void mk_exp(input int ncp);
      exp_q.delete();
      for (int j = 0; j < N + ncp; j++) begin
         smp_t e;
         int   a;
         a     = (j < ncp) ? N - ncp + j : j - ncp;
         e.i   = red(sym_i[a]);
         e.q   = red(sym_q[a]);
         e.sop = (j == 0);
         e.eop = (j == N + ncp - 1);
         e.cpf = (j < ncp);
         exp_q.push_back(e);
      end
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic rand_sym();
      for (int k = 0; k < N; k++) begin
         sym_i[k] = DW'($urandom);
         sym_q[k] = DW'($urandom);
      end
   endtask

   // Offer sym_i/sym_q until all N samples are accepted (bounded).
   task automatic send_sym();
      int k = 0, g = 0;
      bit acc;
      while (k < N && g < 400) begin
         in_valid = 1'b1; in_i = sym_i[k]; in_q = sym_q[k];
         acc = if4.in_ready;
         tick(); g++;
         if (acc) begin k++; last_acc = cyc; end
      end
      in_valid = 1'b0;
      n_vec++;
      if (k != N) begin n_err++; $display("FAIL send_timeout accepted %0d need %0d", k, N); end
   endtask

   task automatic wait_q(input bit sel0, input int n, input int budget);
      for (int c = 0; c < budget; c++) begin
         if ((sel0 ? mq0.size() : mq4.size()) >= n) break;
         tick();
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      n_vec++;
      if ({if4.in_ready, if4.out_valid, if4.out_sop, if4.out_eop, if4.out_cp} !== 5'b10000) begin
         n_err++; $display("FAIL reset_ctl got %b exp 10000", {if4.in_ready, if4.out_valid, if4.out_sop, if4.out_eop, if4.out_cp});
      end
      n_vec++;
      if ({if4.out_data_i, if4.out_data_q, if4.sym_count} !== 48'h0) begin
         n_err++; $display("FAIL reset_data got %h exp 0", {if4.out_data_i, if4.out_data_q, if4.sym_count});
      end
      @(negedge clk) rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int first, last;
      for (int k = 0; k < N; k++) begin sym_i[k] = DW'(k << 6); sym_q[k] = DW'(-(k << 6)); end
      mq4.delete(); mc4.delete(); out_ready = 1'b1;
      send_sym();
      wait_q(0, FR, 100);
      mk_exp(CP);
      n_vec++;
      if (mq4.size() != FR) begin n_err++; $display("FAIL basic_len got %0d exp %0d", mq4.size(), FR); end
      for (int j = 0; j < FR && j < mq4.size(); j++) begin
         n_vec++;
         if (mq4[j] !== exp_q[j]) begin n_err++; $display("FAIL basic_smp[%0d] got %h exp %h", j, mq4[j], exp_q[j]); end
      end
      first = (mc4.size() > 0) ? mc4[0] : -1;
      last  = (mc4.size() > 0) ? mc4[mc4.size()-1] : -1;
      n_vec++;
      if (first != last_acc + 1) begin n_err++; $display("FAIL basic_latency got %0d exp %0d", first, last_acc + 1); end
      n_vec++;
      if (last - first != FR - 1) begin n_err++; $display("FAIL basic_span got %0d exp %0d", last - first, FR - 1); end
      exp_sym++;
      n_vec++;
      if (if4.sym_count !== 16'(exp_sym)) begin n_err++; $display("FAIL basic_symcnt got %0d exp %0d", if4.sym_count, exp_sym); end
   endtask

   task automatic test_stall();
      smp_t cur, prev;
      bit   pst = 1'b0, rdy = 1'b1;
      int   vcnt = 0, inr_bad = 0;
      for (int k = 0; k < N; k++) begin sym_i[k] = DW'(k << 6); sym_q[k] = DW'(-(k << 6)); end
      mq4.delete(); out_ready = 1'b1;
      send_sym();
      for (int c = 0; c < 150 && mq4.size() < FR; c++) begin
         @(negedge clk);
         cur.i = if4.out_data_i; cur.q = if4.out_data_q; cur.sop = if4.out_sop; cur.eop = if4.out_eop; cur.cpf = if4.out_cp;
         if (pst) begin
            n_vec++;
            if (cur !== prev || !if4.out_valid) begin n_err++; $display("FAIL stall_hold got %h exp %h", cur, prev); end
         end
         if (if4.out_valid) vcnt++;
         if (if4.out_valid && if4.in_ready) inr_bad++;
         pst = if4.out_valid && !out_ready;
         prev = cur;
         tick();
         rdy = !rdy; out_ready = rdy;
      end
      out_ready = 1'b1;
      mk_exp(CP);
      n_vec++;
      if (mq4.size() != FR) begin n_err++; $display("FAIL stall_len got %0d exp %0d", mq4.size(), FR); end
      for (int j = 0; j < FR && j < mq4.size(); j++) begin
         n_vec++;
         if (mq4[j] !== exp_q[j]) begin n_err++; $display("FAIL stall_smp[%0d] got %h exp %h", j, mq4[j], exp_q[j]); end
      end
      n_vec++;
      if (vcnt != 2 * FR) begin n_err++; $display("FAIL stall_cycles got %0d exp %0d", vcnt, 2 * FR); end
      n_vec++;
      if (inr_bad != 0) begin n_err++; $display("FAIL stall_in_ready got %0d exp 0", inr_bad); end
      exp_sym++;
      n_vec++;
      if (if4.sym_count !== 16'(exp_sym)) begin n_err++; $display("FAIL stall_symcnt got %0d exp %0d", if4.sym_count, exp_sym); end
   endtask

   // in_valid held high: offers 0..15 accepted, 16+1+20 cycles later the next offer (37) starts a new symbol.
   task automatic test_back_to_back();
      logic exp_rdy;
      for (int o = 0; o < 53; o++) begin off_i[o] = DW'($urandom); off_q[o] = DW'($urandom); end
      mq4.delete(); out_ready = 1'b1;
      for (int o = 0; o < 53; o++) begin
         in_valid = 1'b1; in_i = off_i[o]; in_q = off_q[o];
         exp_rdy = (o < N) || (o >= N + 1 + FR);
         n_vec++;
         if (if4.in_ready !== exp_rdy) begin n_err++; $display("FAIL b2b_in_ready[%0d] got %b exp %b", o, if4.in_ready, exp_rdy); end
         tick();
      end
      in_valid = 1'b0;
      wait_q(0, 2 * FR, 150);
      n_vec++;
      if (mq4.size() != 2 * FR) begin n_err++; $display("FAIL b2b_len got %0d exp %0d", mq4.size(), 2 * FR); end
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < N; k++) begin
            sym_i[k] = off_i[(f == 0) ? k : 37 + k];
            sym_q[k] = off_q[(f == 0) ? k : 37 + k];
         end
         mk_exp(CP);
         for (int j = 0; j < FR && f * FR + j < mq4.size(); j++) begin
            n_vec++;
            if (mq4[f*FR+j] !== exp_q[j]) begin n_err++; $display("FAIL b2b_smp[%0d][%0d] got %h exp %h", f, j, mq4[f*FR+j], exp_q[j]); end
         end
      end
      exp_sym += 2;
      n_vec++;
      if (if4.sym_count !== 16'(exp_sym)) begin n_err++; $display("FAIL b2b_symcnt got %0d exp %0d", if4.sym_count, exp_sym); end
   endtask

   task automatic test_mid_reset();
      rand_sym();
      for (int k = 0; k < 7; k++) begin
         in_valid = 1'b1; in_i = sym_i[k]; in_q = sym_q[k];
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_vec++;
      if ({if4.in_ready, if4.out_valid, if4.out_sop, if4.out_eop, if4.out_cp} !== 5'b10000) begin
         n_err++; $display("FAIL midrst_ctl got %b exp 10000", {if4.in_ready, if4.out_valid, if4.out_sop, if4.out_eop, if4.out_cp});
      end
      n_vec++;
      if ({if4.out_data_i, if4.out_data_q, if4.sym_count} !== 48'h0) begin
         n_err++; $display("FAIL midrst_data got %h exp 0", {if4.out_data_i, if4.out_data_q, if4.sym_count});
      end
      exp_sym = 0;
      @(negedge clk) rst = 1'b0;
      tick();
      rand_sym();
      mq4.delete(); out_ready = 1'b1;
      send_sym();
      wait_q(0, FR, 100);
      mk_exp(CP);
      n_vec++;
      if (mq4.size() != FR) begin n_err++; $display("FAIL midrst_len got %0d exp %0d", mq4.size(), FR); end
      for (int j = 0; j < FR && j < mq4.size(); j++) begin
         n_vec++;
         if (mq4[j] !== exp_q[j]) begin n_err++; $display("FAIL midrst_smp[%0d] got %h exp %h", j, mq4[j], exp_q[j]); end
      end
      exp_sym++;
      n_vec++;
      if (if4.sym_count !== 16'(exp_sym)) begin n_err++; $display("FAIL midrst_symcnt got %0d exp %0d", if4.sym_count, exp_sym); end
   endtask

   task automatic test_random();
      for (int s = 0; s < 3; s++) begin
         rand_sym();
         mq4.delete(); out_ready = 1'b1;
         send_sym();
         for (int c = 0; c < 400 && mq4.size() < FR; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
         end
         out_ready = 1'b1;
         mk_exp(CP);
         n_vec++;
         if (mq4.size() != FR) begin n_err++; $display("FAIL rand_len[%0d] got %0d exp %0d", s, mq4.size(), FR); end
         for (int j = 0; j < FR && j < mq4.size(); j++) begin
            n_vec++;
            if (mq4[j] !== exp_q[j]) begin n_err++; $display("FAIL rand_smp[%0d][%0d] got %h exp %h", s, j, mq4[j], exp_q[j]); end
         end
         exp_sym++;
         n_vec++;
         if (if4.sym_count !== 16'(exp_sym)) begin n_err++; $display("FAIL rand_symcnt got %0d exp %0d", if4.sym_count, exp_sym); end
      end
   endtask

   task automatic test_cp0();
      rst = 1'b1;
      #2 rst = 1'b0;
      exp_sym = 0;
      tick();
      rand_sym();
      mq4.delete(); mq0.delete(); out_ready = 1'b1;
      send_sym();
      wait_q(0, FR, 100);
      mk_exp(0);
      n_vec++;
      if (mq0.size() != N) begin n_err++; $display("FAIL cp0_len got %0d exp %0d", mq0.size(), N); end
      for (int j = 0; j < N && j < mq0.size(); j++) begin
         n_vec++;
         if (mq0[j] !== exp_q[j]) begin n_err++; $display("FAIL cp0_smp[%0d] got %h exp %h", j, mq0[j], exp_q[j]); end
      end
      n_vec++;
      if (if0.sym_count !== 16'd1) begin n_err++; $display("FAIL cp0_symcnt got %0d exp 1", if0.sym_count); end
      exp_sym++;
   endtask

   task automatic test_width();
      logic [OW-1:0] e0, e1, e2, e3;
`ifdef OFDM_CP_ROUND_EN
      e0 = 16'h0001; e1 = 16'h0000; e2 = 16'h7FFF; e3 = 16'h0000;
`else
      e0 = 16'h0000; e1 = 16'h0000; e2 = 16'h7FFF; e3 = 16'hFFFF;
`endif
      rand_sym();
      sym_i[0] = 22'h000020; sym_i[1] = 22'h00001F; sym_i[2] = 22'h1FFFFF; sym_i[3] = 22'h3FFFFF;
      sym_q[0] = 22'h3FFFE0; sym_q[1] = 22'h200000; sym_q[2] = 22'h00003F; sym_q[3] = 22'h1FFFE0;
      mq4.delete(); out_ready = 1'b1;
      send_sym();
      wait_q(0, FR, 100);
      mk_exp(CP);
      n_vec++;
      if (mq4.size() != FR) begin n_err++; $display("FAIL width_len got %0d exp %0d", mq4.size(), FR); end
      for (int j = 0; j < FR && j < mq4.size(); j++) begin
         n_vec++;
         if (mq4[j] !== exp_q[j]) begin n_err++; $display("FAIL width_smp[%0d] got %h exp %h", j, mq4[j], exp_q[j]); end
      end
      if (mq4.size() >= FR) begin
         n_vec++;
         if ({mq4[CP].i, mq4[CP+1].i, mq4[CP+2].i, mq4[CP+3].i} !== {e0, e1, e2, e3}) begin
            n_err++; $display("FAIL width_const got %h %h %h %h exp %h %h %h %h",
               mq4[CP].i, mq4[CP+1].i, mq4[CP+2].i, mq4[CP+3].i, e0, e1, e2, e3);
         end
      end
      exp_sym++;
      n_vec++;
      if (if4.sym_count !== 16'(exp_sym)) begin n_err++; $display("FAIL width_symcnt got %0d exp %0d", if4.sym_count, exp_sym); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_back_to_back();
      test_mid_reset();
      test_random();
      test_cp0();
      test_width();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ofdm_cp_insert.md
Name: ofdm_cp_insert

Overview:
- Cyclic-prefix inserter directly downstream of the inverse myFFT in the OFDM transmit chain.
- Captures one time-domain symbol of FFT_SIZE complex samples into an internal buffer and narrows each sample from DATA_WIDTH to OUT_WIDTH bits.
- Replays the last CP_LEN samples, then the whole symbol, as a framed stream for the DAC/packet stage.
- Drives the IFFT's flag_ready_recive input through in_ready.

Parameters:
- FFT_SIZE, 256, samples per OFDM symbol; power of 2, at least 4.
- CP_LEN, 64, cyclic-prefix length in samples; legal range 0..FFT_SIZE-1.
- DATA_WIDTH, 22, input sample width, signed two's complement.
- OUT_WIDTH, 16, output sample width, signed; must be less than or equal to DATA_WIDTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample strobe; connects to the IFFT complete output.
- in_data_i  in  DATA_WIDTH  input real part.
- in_data_q  in  DATA_WIDTH  input imaginary part.
- in_ready  out  1  block can accept a sample; connects to the IFFT flag_ready_recive input.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_data_i  out  OUT_WIDTH  output real part.
- out_data_q  out  OUT_WIDTH  output imaginary part.
- out_sop  out  1  first sample of the framed symbol (first CP sample).
- out_eop  out  1  last sample of the framed symbol.
- out_cp  out  1  current output sample belongs to the prefix.
- sym_count  out  16  count of completed output symbols.

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; out_data_i/q=0; out_sop=0; out_eop=0; out_cp=0; sym_count=0. Write and read addresses are 0.
- Reset mid-symbol: the partial symbol is discarded and buffer contents are don't-care.
- State machine:
  - IDLE: in_ready=1. An accepted sample (in_valid && in_ready) is written to address 0 and the state moves to LOAD.
  - LOAD: in_ready=1. Each accepted sample is written to the next address. When sample FFT_SIZE-1 is accepted, in_ready drops on the next edge. The state then moves to EMIT_CP, or to EMIT_SYM if CP_LEN=0.
  - EMIT_CP: in_ready=0. Reads addresses FFT_SIZE-CP_LEN..FFT_SIZE-1 with out_cp=1.
  - EMIT_SYM: in_ready=0. Reads addresses 0..FFT_SIZE-1 with out_cp=0.
  - After the last sample is accepted (out_valid && out_ready with out_eop=1), the state returns to IDLE, in_ready=1 and sym_count increments.
- sym_count wraps from 0xFFFF to 0.
- in_valid while in_ready=0 is ignored. No sample is stored and no error is flagged.
- Latency: the last input sample is accepted at edge N. The first output sample is presented with out_valid=1 after edge N+1.
- Output registers: out_data_i/q, out_sop, out_eop and out_cp are all registered.
- Output handshake:
  - A sample transfers on a clock where out_valid && out_ready.
  - While out_valid=1 && out_ready=0, all output registers hold.
  - With out_ready held at 1, exactly FFT_SIZE+CP_LEN consecutive valid cycles are produced.
- Framing flags:
  - out_sop=1 only on the first output sample: address FFT_SIZE-CP_LEN, or address 0 if CP_LEN=0.
  - out_eop=1 only on address FFT_SIZE-1 in EMIT_SYM.
- Width reduction (default): output = input[DATA_WIDTH-1 -: OUT_WIDTH], i.e. arithmetic truncation dropping the DATA_WIDTH-OUT_WIDTH LSBs. No saturation is needed in this mode.
- Symbol throughput: one symbol per FFT_SIZE load cycles plus FFT_SIZE+CP_LEN emit cycles. No overlap of load and emit.

Optional Feature:
- Macro: OFDM_CP_ROUND_EN.
- Defined:
  - Width reduction becomes round-half-up: add 1 at bit position DATA_WIDTH-OUT_WIDTH-1, then take the top OUT_WIDTH bits of the DATA_WIDTH+1-bit sum.
  - Results above the OUT_WIDTH maximum saturate to the maximum (0x7FFF at OUT_WIDTH=16).
  - Rounding happens in the output register stage; latency is unchanged.
- Undefined: plain truncation as described under Behaviour.
- If DATA_WIDTH=OUT_WIDTH, the macro has no effect.

Test Plan:
- Bench parameters FFT_SIZE=16, CP_LEN=4. Input k=0..15 with in_data_i=k<<6, in_data_q=-(k<<6), out_ready=1 -> output i sequence 12,13,14,15,0,1..15; q is the negation; out_sop on the first sample, out_cp on the first 4, out_eop on the 20th; sym_count=1.
- Same stimulus, out_ready toggling 1,0 every cycle -> identical 20-sample sequence, outputs held during stalls, 40 cycles total; in_ready=0 throughout emission.
- in_valid held high continuously for 40 samples -> first 16 accepted; samples offered while in_ready=0 are dropped; in_ready returns to 1 one cycle after eop transfer; the next accepted sample lands at address 0.
- reset pulsed after 7 of 16 samples loaded -> all outputs at reset values immediately; a fresh 16-sample symbol afterwards yields a correct 20-sample frame.
- CP_LEN=0 build -> 16 output samples, out_sop and out_cp behaviour correct (sop on address 0, out_cp never set).
- With OFDM_CP_ROUND_EN, DATA_WIDTH=22, OUT_WIDTH=16 -> input 0x00020 gives 1, 0x0001F gives 0, 0x1FFFFF gives 0x7FFF; without the macro, 0x00020 gives 0.
